lock_ctrl: RTL and testbench



---
 rtl/lock_pkg.sv | 25 ++
 rtl/key_edge_sync.sv | 50 +++++
 rtl/lock_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_lock_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// lock_pkg: shared definitions for the password-lock controller.
//   - lock_state_e : controller FSM states
//   - KEY_*        : decoded keypad codes with a control meaning
//   - is_digit     : true for key codes 0x0..0x9
package lock_pkg;

    typedef enum logic [2:0] {
        ENTRY  = 3'd0,
        CHECK  = 3'd1,
        FAIL   = 3'd2,
        OPEN   = 3'd3,
        ALARM  = 3'd4,
        SETNEW = 3'd5
    } lock_state_e;

    localparam logic [3:0] KEY_ENTER  = 4'hA;
    localparam logic [3:0] KEY_CLEAR  = 4'hB;
    localparam logic [3:0] KEY_CHANGE = 4'hC;
    localparam logic [3:0] KEY_LOCK   = 4'hF;

    function automatic logic is_digit(input logic [3:0] key);
        return (key <= 4'h9);
    endfunction

endpackage

// File: rtl/key_edge_sync.sv
// key_edge_sync: brings the asynchronous key_down level into the clk domain
// and turns each press into a single-cycle strobe with the key code captured.
//   clk       in  system clock
//   reset     in  asynchronous active-high reset
//   key_value in  decoded key code, stable while key_down=1
//   key_down  in  key held level (asynchronous)
//   key_stb   out one-cycle strobe, high 3 clk after key_down is first sampled
//   key_code  out key code captured with the strobe
module key_edge_sync (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key_value,
    input  logic       key_down,
    output logic       key_stb,
    output logic [3:0] key_code
);

    logic [1:0] sync_r;
    logic       level_r;
    logic       level_d_r;
    logic       key_stb_r;
    logic [3:0] key_code_r;
    logic       rise_s;

    // A rise is a synchronised level that was low one cycle earlier.
    assign rise_s = level_r & ~level_d_r;

    // Two-stage synchroniser, level history and registered strobe/code.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_r     <= 2'b00;
            level_r    <= 1'b0;
            level_d_r  <= 1'b0;
            key_stb_r  <= 1'b0;
            key_code_r <= 4'h0;
        end else begin
            sync_r    <= {sync_r[0], key_down};
            level_r   <= sync_r[1];
            level_d_r <= level_r;
            key_stb_r <= rise_s;
            if (rise_s) begin
                key_code_r <= key_value;
            end
        end
    end

    assign key_stb  = key_stb_r;
    assign key_code = key_code_r;

endmodule

// File: rtl/lock_ctrl.sv
// lock_ctrl: keypad password lock. Collects digits, compares them with the
// stored code, opens with timed auto-relock, counts consecutive failures and
// raises a timed alarm after MAX_FAIL wrong codes.
// Optional feature macro: LOCK_CODE_CHANGE_EN (CHANGE key in OPEN lets the
// user program a new code; without it the code is the constant DEFAULT_CODE).
//   clk       in  system clock
//   reset     in  asynchronous active-high reset
//   key_value in  decoded key code from the scanner
//   key_down  in  key held level (asynchronous)
//   unlock    out lock open
//   alarm     out alarm active
//   err       out one-cycle pulse on a rejected entry
//   digit_cnt out digits currently buffered
//   fail_cnt  out consecutive failures so far
module lock_ctrl
    import lock_pkg::*;
#(
    parameter int                      CODE_LEN     = 4,
    parameter logic [4*CODE_LEN-1:0]   DEFAULT_CODE = 16'h1234,
    parameter int                      MAX_FAIL     = 3,
    parameter int                      OPEN_CYC     = 50_000_000,
    parameter int                      ALARM_CYC    = 100_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key_value,
    input  logic       key_down,
    output logic       unlock,
    output logic       alarm,
    output logic       err,
    output logic [3:0] digit_cnt,
    output logic [2:0] fail_cnt
);

    localparam int BW   = 4 * CODE_LEN;
    localparam int TMAX = (OPEN_CYC > ALARM_CYC) ? OPEN_CYC : ALARM_CYC;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [3:0]    LEN_C      = 4'(CODE_LEN);
    localparam logic [2:0]    MAX_FAIL_C = 3'(MAX_FAIL);
    // Timers are loaded with N-1 so the state lasts exactly N cycles.
    localparam logic [TW-1:0] OPEN_LD_C  = TW'(OPEN_CYC - 1);
    localparam logic [TW-1:0] ALARM_LD_C = TW'(ALARM_CYC - 1);

    logic          key_stb_s;
    logic [3:0]    key_code_s;

    lock_state_e   state_r, state_n;
    logic [BW-1:0] buf_r, buf_n;
    logic [3:0]    cnt_r, cnt_n;
    logic [2:0]    fail_r, fail_n;
    logic [TW-1:0] timer_r, timer_n;
    logic          err_n;
    logic          unlock_r, alarm_r, err_r;
    logic [BW-1:0] code_s;

`ifdef LOCK_CODE_CHANGE_EN
    logic [BW-1:0] code_r, code_n;
    assign code_s = code_r;
`else
    assign code_s = DEFAULT_CODE;
`endif

    key_edge_sync u_key_edge_sync (
        .clk       (clk),
        .reset     (reset),
        .key_value (key_value),
        .key_down  (key_down),
        .key_stb   (key_stb_s),
        .key_code  (key_code_s)
    );

    // Next-state, buffer, counter and timer logic.
    always_comb begin
        state_n = state_r;
        buf_n   = buf_r;
        cnt_n   = cnt_r;
        fail_n  = fail_r;
        timer_n = timer_r;
        err_n   = 1'b0;
`ifdef LOCK_CODE_CHANGE_EN
        code_n  = code_r;
`endif
        case (state_r)
            ENTRY: begin
                if (key_stb_s) begin
                    if (is_digit(key_code_s)) begin
                        // Digits beyond CODE_LEN are dropped; count saturates.
                        if (cnt_r < LEN_C) begin
                            buf_n      = buf_r << 3'd4;
                            buf_n[3:0] = key_code_s;
                            cnt_n      = cnt_r + 4'd1;
                        end else begin
                            buf_n = buf_r;
                        end
                    end else if (key_code_s == KEY_ENTER) begin
                        if (cnt_r == LEN_C) begin
                            state_n = CHECK;
                        end else begin
                            err_n = 1'b1;
                            buf_n = '0;
                            cnt_n = 4'd0;
                        end
                    end else if (key_code_s == KEY_CLEAR) begin
                        buf_n = '0;
                        cnt_n = 4'd0;
                    end else begin
                        state_n = ENTRY;
                    end
                end else begin
                    state_n = ENTRY;
                end
            end
            CHECK: begin
                buf_n = '0;
                cnt_n = 4'd0;
                if (buf_r == code_s) begin
                    state_n = OPEN;
                    fail_n  = 3'd0;
                    timer_n = OPEN_LD_C;
                end else if ((fail_r + 3'd1) == MAX_FAIL_C) begin
                    state_n = ALARM;
                    timer_n = ALARM_LD_C;
                end else begin
                    state_n = FAIL;
                    fail_n  = fail_r + 3'd1;
                    err_n   = 1'b1;
                end
            end
            FAIL: begin
                state_n = ENTRY;
            end
            OPEN: begin
                // Expiry wins over a key arriving in the same cycle.
                if (timer_r == '0) begin
                    state_n = ENTRY;
                end else begin
                    timer_n = timer_r - TW'(1);
                    if (key_stb_s && (key_code_s == KEY_LOCK)) begin
                        state_n = ENTRY;
                    end else if (key_stb_s && (key_code_s == KEY_CHANGE)) begin
`ifdef LOCK_CODE_CHANGE_EN
                        state_n = SETNEW;
                        timer_n = timer_r;
`else
                        state_n = OPEN;
`endif
                    end else begin
                        state_n = OPEN;
                    end
                end
            end
            ALARM: begin
                if (timer_r == '0) begin
                    state_n = ENTRY;
                    fail_n  = 3'd0;
                end else begin
                    timer_n = timer_r - TW'(1);
                end
            end
`ifdef LOCK_CODE_CHANGE_EN
            SETNEW: begin
                // Timer stays frozen while a new code is being typed.
                if (key_stb_s) begin
                    if (is_digit(key_code_s)) begin
                        if (cnt_r < LEN_C) begin
                            buf_n      = buf_r << 3'd4;
                            buf_n[3:0] = key_code_s;
                            cnt_n      = cnt_r + 4'd1;
                        end else begin
                            buf_n = buf_r;
                        end
                    end else if (key_code_s == KEY_ENTER) begin
                        buf_n = '0;
                        cnt_n = 4'd0;
                        if (cnt_r == LEN_C) begin
                            code_n  = buf_r;
                            state_n = OPEN;
                            timer_n = OPEN_LD_C;
                        end else begin
                            err_n = 1'b1;
                        end
                    end else if (key_code_s == KEY_CLEAR) begin
                        buf_n   = '0;
                        cnt_n   = 4'd0;
                        state_n = OPEN;
                    end else begin
                        state_n = SETNEW;
                    end
                end else begin
                    state_n = SETNEW;
                end
            end
`endif
            default: begin
                state_n = ENTRY;
                buf_n   = '0;
                cnt_n   = 4'd0;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= ENTRY;
            buf_r    <= '0;
            cnt_r    <= 4'd0;
            fail_r   <= 3'd0;
            timer_r  <= '0;
            unlock_r <= 1'b0;
            alarm_r  <= 1'b0;
            err_r    <= 1'b0;
`ifdef LOCK_CODE_CHANGE_EN
            code_r   <= DEFAULT_CODE;
`endif
        end else begin
            state_r  <= state_n;
            buf_r    <= buf_n;
            cnt_r    <= cnt_n;
            fail_r   <= fail_n;
            timer_r  <= timer_n;
            unlock_r <= (state_n == OPEN) || (state_n == SETNEW);
            alarm_r  <= (state_n == ALARM);
            err_r    <= err_n;
`ifdef LOCK_CODE_CHANGE_EN
            code_r   <= code_n;
`endif
        end
    end

    assign unlock    = unlock_r;
    assign alarm     = alarm_r;
    assign err       = err_r;
    assign digit_cnt = cnt_r;
    assign fail_cnt  = fail_r;

endmodule

// File: tb/tb_lock_ctrl.sv
// tb_lock_ctrl: directed self-checking bench for lock_ctrl with short timers
// (OPEN_CYC=20, ALARM_CYC=30). Honours LOCK_CODE_CHANGE_EN when defined.
module tb_lock_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] key_value;
    logic       key_down;
    logic       unlock;
    logic       alarm;
    logic       err;
    logic [3:0] digit_cnt;
    logic [2:0] fail_cnt;

    int total = 0;
    int bad   = 0;
    int unl_hi = 0;
    int al_hi  = 0;
    int err_hi = 0;
    int snap_u, snap_a, snap_e;

    lock_ctrl #(
        .CODE_LEN     (4),
        .DEFAULT_CODE (16'h1234),
        .MAX_FAIL     (3),
        .OPEN_CYC     (20),
        .ALARM_CYC    (30)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .key_value (key_value),
        .key_down  (key_down),
        .unlock    (unlock),
        .alarm     (alarm),
        .err       (err),
        .digit_cnt (digit_cnt),
        .fail_cnt  (fail_cnt)
    );

    always #5 clk = ~clk;

    // Cycle counts of high outputs, sampled on the falling edge.
    always @(negedge clk) begin
        if (unlock) unl_hi <= unl_hi + 1;
        if (alarm)  al_hi  <= al_hi + 1;
        if (err)    err_hi <= err_hi + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Call at a falling edge; returns at the falling edge after the FSM acted.
    task automatic press(input logic [3:0] v);
        key_value = v;
        key_down  = 1'b1;
        repeat (2) @(negedge clk);
        key_down  = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic press4(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [3:0] d);
        press(a); press(b); press(c); press(d);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; key_down = 1'b0; key_value = 4'h0;
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(1);
        chk("rst_unlock", {31'd0, unlock}, 32'd0);
        chk("rst_alarm",  {31'd0, alarm},  32'd0);
        chk("rst_err",    {31'd0, err},    32'd0);
        chk("rst_dcnt",   {28'd0, digit_cnt}, 32'd0);
        chk("rst_fcnt",   {29'd0, fail_cnt},  32'd0);

        // Correct code with exact open latency and open duration.
        press4(4'h1, 4'h2, 4'h3, 4'h4);
        chk("ok_dcnt4", {28'd0, digit_cnt}, 32'd4);
        snap_u = unl_hi;
        key_value = 4'hA; key_down = 1'b1;
        repeat (5) @(posedge clk); #1;
        chk("ok_check_cyc", {31'd0, unlock}, 32'd0);
        @(posedge clk); #1;
        chk("ok_open", {31'd0, unlock}, 32'd1);
        chk("ok_fcnt", {29'd0, fail_cnt}, 32'd0);
        @(negedge clk);
        key_down = 1'b0;
        for (int i = 0; i < 100 && unlock === 1'b1; i++) @(negedge clk);
        #1;
        chk("relock", {31'd0, unlock}, 32'd0);
        chk("open_len", 32'(unl_hi - snap_u), 32'd20);
        @(negedge clk);

        // Short entry.
        press(4'h1); press(4'h2);
        chk("short_dcnt2", {28'd0, digit_cnt}, 32'd2);
        snap_e = err_hi;
        press(4'hA);
        chk("short_err_hi", {31'd0, err}, 32'd1);
        wait_cyc(1);
        chk("short_err_lo", {31'd0, err}, 32'd0);
        chk("short_err_cnt", 32'(err_hi - snap_e), 32'd1);
        chk("short_dcnt0", {28'd0, digit_cnt}, 32'd0);
        chk("short_unlock", {31'd0, unlock}, 32'd0);
        chk("short_fcnt", {29'd0, fail_cnt}, 32'd0);

        // Lockout: two failures then alarm.
        for (int a = 1; a <= 2; a++) begin
            snap_e = err_hi;
            press4(4'h9, 4'h9, 4'h9, 4'h9);
            press(4'hA);
            wait_cyc(2);
            chk("bad_err", 32'(err_hi - snap_e), 32'd1);
            chk("bad_fcnt", {29'd0, fail_cnt}, 32'(a));
        end
        snap_e = err_hi;
        snap_a = al_hi;
        press4(4'h9, 4'h9, 4'h9, 4'h9);
        press(4'hA);
        wait_cyc(1);
        chk("alarm_on", {31'd0, alarm}, 32'd1);
        chk("alarm_excl", {31'd0, alarm & unlock}, 32'd0);
        chk("alarm_fcnt", {29'd0, fail_cnt}, 32'd2);
        press4(4'h1, 4'h2, 4'h3, 4'h4);
        press(4'hA);
        chk("alarm_keys_dcnt", {28'd0, digit_cnt}, 32'd0);
        chk("alarm_still", {31'd0, alarm}, 32'd1);
        chk("alarm_no_open", {31'd0, unlock}, 32'd0);
        for (int i = 0; i < 100 && alarm === 1'b1; i++) @(negedge clk);
        #1;
        chk("alarm_off", {31'd0, alarm}, 32'd0);
        chk("alarm_len", 32'(al_hi - snap_a), 32'd30);
        chk("alarm_no_err", 32'(err_hi - snap_e), 32'd0);
        chk("alarm_fcnt0", {29'd0, fail_cnt}, 32'd0);
        @(negedge clk);

        // Held key gives one digit; overflow digits are dropped.
        key_value = 4'h5; key_down = 1'b1;
        wait_cyc(100);
        key_down = 1'b0;
        wait_cyc(5);
        chk("hold_dcnt1", {28'd0, digit_cnt}, 32'd1);
        press(4'hB);
        chk("clear_dcnt0", {28'd0, digit_cnt}, 32'd0);
        press4(4'h1, 4'h2, 4'h3, 4'h4);
        press(4'h6);
        chk("ovf_dcnt4", {28'd0, digit_cnt}, 32'd4);
        press(4'hA);
        wait_cyc(1);
        chk("ovf_open", {31'd0, unlock}, 32'd1);
        press(4'hF);
        chk("lock_key", {31'd0, unlock}, 32'd0);

`ifdef LOCK_CODE_CHANGE_EN
        // Program 5678, then old code fails and new code opens.
        press4(4'h1, 4'h2, 4'h3, 4'h4);
        press(4'hA);
        wait_cyc(1);
        press(4'hC);
        press4(4'h5, 4'h6, 4'h7, 4'h8);
        chk("set_dcnt4", {28'd0, digit_cnt}, 32'd4);
        chk("set_unlock", {31'd0, unlock}, 32'd1);
        press(4'hA);
        chk("set_back_open", {31'd0, unlock}, 32'd1);
        press(4'hF);
        chk("set_locked", {31'd0, unlock}, 32'd0);
        press4(4'h1, 4'h2, 4'h3, 4'h4);
        press(4'hA);
        wait_cyc(2);
        chk("old_code_fcnt", {29'd0, fail_cnt}, 32'd1);
        chk("old_code_shut", {31'd0, unlock}, 32'd0);
        press4(4'h5, 4'h6, 4'h7, 4'h8);
        press(4'hA);
        wait_cyc(1);
        chk("new_code_open", {31'd0, unlock}, 32'd1);
        chk("new_code_fcnt", {29'd0, fail_cnt}, 32'd0);
`else
        // CHANGE is inert without the code-change feature.
        press4(4'h1, 4'h2, 4'h3, 4'h4);
        press(4'hA);
        wait_cyc(1);
        press(4'hC);
        press(4'h5);
        chk("change_ign_unlock", {31'd0, unlock}, 32'd1);
        chk("change_ign_dcnt", {28'd0, digit_cnt}, 32'd0);
        press(4'hF);
        chk("change_ign_lock", {31'd0, unlock}, 32'd0);
        press4(4'h1, 4'h2, 4'h3, 4'h4);
        press(4'hA);
        wait_cyc(1);
`endif

        // Reset while open, then the default code works again.
        chk("pre_rst_open", {31'd0, unlock}, 32'd1);
        reset = 1'b1;
        #1;
        chk("midrst_unlock", {31'd0, unlock}, 32'd0);
        chk("midrst_dcnt", {28'd0, digit_cnt}, 32'd0);
        chk("midrst_fcnt", {29'd0, fail_cnt}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        wait_cyc(1);
        press4(4'h1, 4'h2, 4'h3, 4'h4);
        press(4'hA);
        wait_cyc(1);
        chk("post_rst_open", {31'd0, unlock}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
